v2k_typedef_yee_pix_arb: RTL and testbench
==========================================

// Module: v2k_typedef_yee_pix_arb
// PURPOSE
//   Round-robin arbiter sharing the sub2 pixel input (sub2_in_pixel) between two pixel_t
//   requesters (e.g. sub1_out_pixel path and pixel_ff path), with bounded bursts.
//   Output is one registered stage; backpressure is sub2's ready.
//   Sits in the top level between itest_sub1/pixel_ff sources and itest_sub2.
// PARAMETERS
//   PIX_W      24  pixel width (pixel24_t)
//   BURST_MAX  4   max beats per grant before rotating (>=1)
//   CNT_W      3   beat counter width; must satisfy 2**CNT_W > BURST_MAX
// PORTS
//   cp          in   1      clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   req0_valid  in   1      requester 0 has a pixel
//   req0_pixel  in   PIX_W  requester 0 pixel
//   req0_ready  out  1      requester 0 beat accepted this cycle (when valid)
//   req1_valid  in   1      requester 1 has a pixel
//   req1_pixel  in   PIX_W  requester 1 pixel
//   req1_ready  out  1      requester 1 beat accepted this cycle (when valid)
//   out_valid   out  1      out_pixel holds a beat for sub2
//   out_pixel   out  PIX_W  registered pixel to sub2_in_pixel
//   out_src     out  1      requester id of current out beat
//   out_ready   in   1      sub2 ready (consumes beat when out_valid)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, rr_ptr=0, beat_cnt=0, out_valid=0,
//     out_pixel=0, out_src=0; req0_ready=req1_ready=0. An undelivered out beat is dropped.
//   States: IDLE, GNT0, GNT1.
//   can_load = !out_valid | out_ready.
//   reqN_ready = (state==GNTn) & can_load (combinational; never in IDLE).
//   xferN = reqN_valid & reqN_ready.
//   On xferN: out_pixel<=reqN_pixel, out_src<=N, out_valid<=1 (latency 1 cycle).
//   Else if out_ready: out_valid<=0.
//   out_valid/out_pixel/out_src are held stable while out_valid & !out_ready.
//   Requesters hold valid/pixel stable until ready.
//   IDLE: if exactly one valid -> GNT of that one.
//     If both valid -> GNT[rr_ptr]. Else stay.
//     No beat moves in the IDLE cycle.
//   GNTn, beat_cnt counts xferN. Grant ends when:
//     (a) xferN & beat_cnt==BURST_MAX-1 (burst done), or
//     (b) !reqN_valid (requester went idle).
//     On end: rr_ptr<=~n; beat_cnt<=0.
//     Next state is GNT(~n) if req(~n)_valid, else GNTn if (a) & reqN_valid, else IDLE.
//     Switching grants costs no bubble.
//   Stall (reqN_valid & !can_load): hold state and beat_cnt; no timeout.
//   Grant is never revoked mid-stall; fairness bound is BURST_MAX beats.
//   Both requesters continuously valid, out_ready=1: output alternates
//     BURST_MAX beats of 0, BURST_MAX of 1, ...
// TESTING
//   1 Reset release, req0 sends 3 pixels 24'h000001..3, out_ready=1
//     -> IDLE 1 cycle, then out beats 1,2,3 src=0 on consecutive cycles, 1 cycle after accept.
//   2 Both valid continuously, BURST_MAX=4, out_ready=1
//     -> src pattern 0000111100001111; no idle cycle between bursts.
//   3 out_ready low 5 cycles mid-burst with out_valid=1
//     -> out_pixel/out_src frozen, reqN_ready=0, beat_cnt unchanged; resumes on release.
//   4 req0 drops valid after 2 beats while req1 valid
//     -> next cycle GNT1; rr_ptr=1; req1 beats follow with no bubble.
//   5 Only req1 valid for 10 beats, BURST_MAX=4
//     -> regrant to 1 after each burst; 10 beats delivered back-to-back.
//   6 reset asserted mid-burst with out_valid=1
//     -> out_valid=0, readys=0 immediately (async); after release, arbitration restarts with rr_ptr=0.

Source files
------------

// File: rtl/v2k_typedef_yee_pix_arb_if.sv
// Pixel arbiter bus: two pixel requesters plus the registered output toward sub2.
// slave = arbiter side, master = requester/sink side.
interface v2k_typedef_yee_pix_arb_if #(
  parameter int PIX_W = 24
);
  logic             req0_valid;
  logic [PIX_W-1:0] req0_pixel;
  logic             req0_ready;
  logic             req1_valid;
  logic [PIX_W-1:0] req1_pixel;
  logic             req1_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic             out_src;
  logic             out_ready;

  modport slave (
    input  req0_valid, req0_pixel, req1_valid, req1_pixel, out_ready,
    output req0_ready, req1_ready, out_valid, out_pixel, out_src
  );

  modport master (
    output req0_valid, req0_pixel, req1_valid, req1_pixel, out_ready,
    input  req0_ready, req1_ready, out_valid, out_pixel, out_src
  );
endinterface

// File: rtl/v2k_typedef_yee_pix_arb.sv
// Round-robin arbiter sharing the sub2 pixel input between two requesters.
// Grants last up to BURST_MAX beats; one registered output stage with backpressure.
module v2k_typedef_yee_pix_arb #(
  parameter int PIX_W     = 24,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3   // 2**CNT_W must exceed BURST_MAX
) (
  input logic                      cp,
  input logic                      reset,
  v2k_typedef_yee_pix_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

  state_t           state, state_nxt;
  logic             rr_ptr, rr_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;

  logic             out_valid_q, out_src_q;
  logic [PIX_W-1:0] out_pixel_q;

  logic                  can_load;
  logic [1:0]            vld, rdy, xfer;
  logic [1:0][PIX_W-1:0] pix;
  logic                  cur_id, cur_valid, oth_valid, cur_xfer;
  logic                  burst_done, grant_end;

  assign vld = {bus.req1_valid, bus.req0_valid};
  assign pix = {bus.req1_pixel, bus.req0_pixel};

  // Output stage can take a new beat when empty or being drained this cycle.
  assign can_load = !out_valid_q || bus.out_ready;
  assign rdy[0]   = (state == GNT0) && can_load;
  assign rdy[1]   = (state == GNT1) && can_load;
  assign xfer     = vld & rdy;

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pixel  = out_pixel_q;
  assign bus.out_src    = out_src_q;

  // Current grant holder view; only meaningful outside IDLE.
  assign cur_id     = (state == GNT1);
  assign cur_valid  = vld[cur_id];
  assign oth_valid  = vld[!cur_id];
  assign cur_xfer   = |xfer;
  assign burst_done = cur_xfer && (beat_cnt == LAST_BEAT);
  // A stalled holder keeps its grant: only a full burst or dropped valid ends it.
  assign grant_end  = (state != IDLE) && (burst_done || !cur_valid);

  // Arbitration state, round-robin pointer and burst counter registers.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Next grant: rotate on grant end, handing over in the same cycle (no bubble).
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (vld == 2'b11)  state_nxt = rr_ptr ? GNT1 : GNT0;
        else if (vld[0])   state_nxt = GNT0;
        else if (vld[1])   state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (grant_end) begin
          rr_nxt  = !cur_id;
          cnt_nxt = '0;
          if (oth_valid)                    state_nxt = cur_id ? GNT0 : GNT1;
          else if (burst_done && cur_valid) state_nxt = state;
          else                              state_nxt = IDLE;
        end else if (cur_xfer) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: load on accepted beat, clear once drained, hold under backpressure.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_src_q   <= 1'b0;
    end else if (cur_xfer) begin
      out_valid_q <= 1'b1;
      out_pixel_q <= pix[xfer[1]];
      out_src_q   <= xfer[1];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v2k_typedef_yee_pix_arb.sv
// Directed bench for the two-requester pixel arbiter (BURST_MAX=4).
module tb_v2k_typedef_yee_pix_arb;

  localparam int PIX_W = 24;
  localparam logic [PIX_W-1:0] B0 = 24'h000001;
  localparam logic [PIX_W-1:0] B1 = 24'h100001;

  logic cp, rst_n;
  v2k_typedef_yee_pix_arb_if #(.PIX_W(PIX_W)) bus ();

  v2k_typedef_yee_pix_arb #(.PIX_W(PIX_W), .BURST_MAX(4), .CNT_W(3)) dut (
    .cp(cp), .reset(rst_n), .bus(bus)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  int n_chk = 0, n_fail = 0;
  int n0, n1, i0, i1, cyc;
  bit en0, en1;
  logic             obs_src[$];
  logic [PIX_W-1:0] obs_pix[$];
  int               obs_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic src, input logic [PIX_W-1:0] px);
    return {7'd0, src, px};
  endfunction

  task automatic drive();
    bus.req0_valid = en0 && (n0 > 0);
    bus.req0_pixel = B0 + PIX_W'(i0);
    bus.req1_valid = en1 && (n1 > 0);
    bus.req1_pixel = B1 + PIX_W'(i1);
  endtask

  // One clock: note handshakes and delivered beats, then advance requesters.
  task automatic tick();
    logic x0, x1;
    x0 = bus.req0_valid & bus.req0_ready;
    x1 = bus.req1_valid & bus.req1_ready;
    if (bus.out_valid && bus.out_ready) begin
      obs_src.push_back(bus.out_src);
      obs_pix.push_back(bus.out_pixel);
      obs_cyc.push_back(cyc);
    end
    @(posedge cp); #1;
    cyc++;
    if (x0) begin i0++; n0--; end
    if (x1) begin i1++; n1--; end
    drive();
    #2;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_obs(input string tag, input int k, input logic src, input logic [PIX_W-1:0] px);
    if (k < obs_src.size()) chk(tag, beat(obs_src[k], obs_pix[k]), beat(src, px));
    else                    chk(tag, 32'hdeadbeef, beat(src, px));
  endtask

  task automatic chk_span(input string tag, input int a, input int b);
    if (b < obs_cyc.size()) chk(tag, 32'(obs_cyc[b] - obs_cyc[a]), 32'(b - a));
    else                    chk(tag, 32'hdeadbeef, 32'(b - a));
  endtask

  task automatic chk_ports(input string tag, input logic r0, input logic r1, input logic ov);
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(r1));
    chk({tag, "_ovld"}, 32'(bus.out_valid), 32'(ov));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en0 = 0; en1 = 0; n0 = 0; n1 = 0; i0 = 0; i1 = 0;
    bus.out_ready = 1'b1;
    drive();
    #1;
    chk_ports("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_opix", 32'(bus.out_pixel), 32'd0);
    chk("rst_osrc", 32'(bus.out_src), 32'd0);
    run(2);
    rst_n = 1'b1;
    obs_src.delete(); obs_pix.delete(); obs_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 0;
    bus.out_ready = 1'b1;
    en0 = 0; en1 = 0; n0 = 0; n1 = 0; i0 = 0; i1 = 0;
    drive();
    @(posedge cp); #3;

    // 1: single requester, 3 beats, cycle exact
    do_reset();
    n0 = 3; en0 = 1; drive(); #1;
    chk_ports("t1_c0", 1'b0, 1'b0, 1'b0);
    tick(); chk_ports("t1_c1", 1'b1, 1'b0, 1'b0);
    tick(); chk("t1_c2", beat(bus.out_src, bus.out_pixel), beat(1'b0, 24'h000001));
    chk("t1_c2_ovld", 32'(bus.out_valid), 32'd1);
    tick(); chk("t1_c3", beat(bus.out_src, bus.out_pixel), beat(1'b0, 24'h000002));
    tick(); chk("t1_c4", beat(bus.out_src, bus.out_pixel), beat(1'b0, 24'h000003));
    chk("t1_c4_ovld", 32'(bus.out_valid), 32'd1);
    tick(); chk_ports("t1_c5", 1'b0, 1'b0, 1'b0);

    // 2: both continuously valid -> 0000111100001111, no gap
    do_reset();
    n0 = 20; n1 = 20; en0 = 1; en1 = 1; drive();
    run(20);
    for (int k = 0; k < 16; k++)
      chk_obs($sformatf("t2_beat%0d", k), k, 1'((k / 4) % 2), (((k / 4) % 2) ? B1 : B0) + PIX_W'((k / 8) * 4 + k % 4));
    chk_span("t2_span", 0, 15);

    // 3: backpressure mid-burst freezes output and keeps burst count
    do_reset();
    n0 = 8; n1 = 8; en0 = 1; en1 = 1; drive();
    run(2);
    bus.out_ready = 1'b0; #1;
    chk_ports("t3_stall", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_hold%0d", k), beat(bus.out_src, bus.out_pixel), beat(1'b0, B0));
      chk_ports($sformatf("t3_hold%0d", k), 1'b0, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1; #1;
    chk("t3_release_rdy0", 32'(bus.req0_ready), 32'd1);
    run(12);
    for (int k = 0; k < 8; k++)
      chk_obs($sformatf("t3_beat%0d", k), k, 1'(k / 4), ((k / 4) ? B1 : B0) + PIX_W'(k % 4));
    chk_span("t3_span", 0, 7);

    // 4: req0 goes idle after 2 beats, req1 takes over
    do_reset();
    n0 = 2; n1 = 8; en0 = 1; en1 = 1; drive();
    tick(); chk_ports("t4_c1", 1'b1, 1'b0, 1'b0);
    tick(); tick(); chk_ports("t4_c3", 1'b1, 1'b0, 1'b1);
    tick(); chk_ports("t4_c4", 1'b0, 1'b1, 1'b0);
    tick(); chk("t4_c5", beat(bus.out_src, bus.out_pixel), beat(1'b1, B1));
    run(6);
    chk_obs("t4_a0", 0, 1'b0, B0);
    chk_obs("t4_a1", 1, 1'b0, B0 + 24'd1);
    for (int k = 0; k < 4; k++)
      chk_obs($sformatf("t4_b%0d", k), k + 2, 1'b1, B1 + PIX_W'(k));
    chk_span("t4_span", 2, 5);

    // 5: lone requester 1, 10 beats back-to-back across regrants
    do_reset();
    n1 = 10; en1 = 1; drive();
    run(14);
    chk("t5_count", 32'(obs_src.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      chk_obs($sformatf("t5_beat%0d", k), k, 1'b1, B1 + PIX_W'(k));
    chk_span("t5_span", 0, 9);
    if (obs_cyc.size() > 0) chk("t5_first_cyc", 32'(obs_cyc[0]), 32'd2);
    else                    chk("t5_first_cyc", 32'hdeadbeef, 32'd2);

    // 6: async reset mid GNT1 burst, restart favours requester 0
    do_reset();
    n0 = 20; n1 = 20; en0 = 1; en1 = 1; drive();
    run(6);
    chk("t6_pre", beat(bus.out_src, bus.out_pixel), beat(1'b1, B1));
    chk("t6_pre_ovld", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk_ports("t6_async", 1'b0, 1'b0, 1'b0);
    run(2);
    rst_n = 1'b1; #1;
    chk_ports("t6_c0", 1'b0, 1'b0, 1'b0);
    tick(); chk_ports("t6_c1", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
